// File: rtl/mem_io_responder.sv
// Far-side memory/IO responder for the CPU byte bus: RAM, UART RX/TX,
// cycle counter with snapshot, and program-stop flag.
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH_LOG2  = 4,
  parameter int FULL_MARGIN    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_wdata,
  input  logic        mem_wr,
  output logic [7:0]  mem_rdata,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int CW    = TX_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_V  = CW'(DEPTH);
  localparam logic [CW-1:0] MARGIN_V = CW'(FULL_MARGIN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [TX_DEPTH_LOG2-1:0] PTR_ONE = TX_DEPTH_LOG2'(1);

  logic [7:0] ram [0:(1 << RAM_ADDR_WIDTH)-1];
  logic [7:0] fifo [0:DEPTH-1];

  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic [2:0]  off;
  logic        en;
  logic        io;
  logic        rd;
  logic        wr;
  logic        ram_we;
  logic        push;
  logic        pop;
  logic        accept;
  logic [7:0]  push_data;
  logic [7:0]  rd_byte;
  logic [31:0] cnt;
  logic [23:0] snap;
  logic [TX_DEPTH_LOG2-1:0] wp;
  logic [TX_DEPTH_LOG2-1:0] rp;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          unused_bits;

  assign unused_bits = ^mem_a;

  assign en       = rdy_in & ~rst_in;
  assign io       = (mem_a[17:16] == 2'b11);
  assign off      = mem_a[2:0];
  assign ram_addr = mem_a[RAM_ADDR_WIDTH-1:0];
  assign rd       = en & ~mem_wr;
  assign wr       = en & mem_wr;
  assign ram_we   = wr & ~io;

  assign rx_ready = rd & io & (off == 3'd0) & rx_valid;

  // Stop marker bypasses the zero filter so the sink sees the terminator.
  assign push = wr & io &
    (((off == 3'd0) && (mem_wdata != 8'h00)) || (off == 3'd4));
  assign push_data = (off == 3'd4) ? 8'h00 : mem_wdata;

  assign tx_valid = (count != '0);
  assign tx_data  = fifo[rp];
  assign pop      = tx_valid & tx_ready;
  assign accept   = push & ((count != DEPTH_V) | pop);

  assign free           = DEPTH_V - count;
  assign io_buffer_full = (free <= MARGIN_V);

  always_comb begin
    rd_byte = 8'h00;
    if (!io) begin
      rd_byte = ram[ram_addr];
    end else begin
      unique case (off)
        3'd0:    rd_byte = rx_valid ? rx_data : 8'h00;
        3'd4:    rd_byte = cnt[7:0];
        3'd5:    rd_byte = snap[7:0];
        3'd6:    rd_byte = snap[15:8];
        3'd7:    rd_byte = snap[23:16];
        default: rd_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_addr] <= mem_wdata;
    if (accept) fifo[wp] <= push_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_rdata    <= 8'h00;
      cnt          <= 32'd0;
      snap         <= 24'd0;
      wp           <= '0;
      rp           <= '0;
      count        <= '0;
      program_stop <= 1'b0;
      tx_overflow  <= 1'b0;
    end else begin
      if (rd) mem_rdata <= rd_byte;
      if (rd && io && (off == 3'd4)) snap <= cnt[31:8];
      if (en && !program_stop) cnt <= cnt + 32'd1;
      if (wr && io && (off == 3'd4)) program_stop <= 1'b1;
      if (push && !accept) tx_overflow <= 1'b1;
      if (accept) wp <= wp + PTR_ONE;
      if (pop) rp <= rp + PTR_ONE;
      unique case ({accept, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, RX, counter snapshot,
// TX FIFO fill/overflow/drain, program stop, rdy_in stall, reset.
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_wdata;
  logic        mem_wr;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        program_stop;
  logic        tx_overflow;

  int errors = 0;
  int total  = 0;

  // Reference counter: counts enabled cycles until the stop write.
  logic [31:0] model_cnt  = 32'd0;
  logic [31:0] model_snap = 32'd0;
  logic        model_stop = 1'b0;
  logic [31:0] frozen;

  mem_io_responder dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_a          (mem_a),
    .mem_wdata      (mem_wdata),
    .mem_wr         (mem_wr),
    .mem_rdata      (mem_rdata),
    .io_buffer_full (io_buffer_full),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .program_stop   (program_stop),
    .tx_overflow    (tx_overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    if (rdy_in && !rst_in) begin
      if (!mem_wr && mem_a[17:0] == 18'h30004) model_snap = model_cnt;
      if (!model_stop) model_cnt = model_cnt + 32'd1;
      if (mem_wr && mem_a[17:0] == 18'h30004) model_stop = 1'b1;
    end
    if (rst_in) begin
      model_cnt  = 32'd0;
      model_stop = 1'b0;
    end
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_in    = 1'b1;
    rdy_in    = 1'b1;
    mem_a     = 32'h0;
    mem_wdata = 8'h00;
    mem_wr    = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    tx_ready  = 1'b0;
    step();
    step();
    rst_in = 1'b0;

    chk("rst_rdata", 32'(mem_rdata), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_full", 32'(io_buffer_full), 32'h0);
    chk("rst_stop", 32'(program_stop), 32'h0);
    chk("rst_ovf", 32'(tx_overflow), 32'h0);

    // Counter: 100 enabled cycles, then snapshot reads.
    repeat (100) step();
    mem_a = 32'h30004; step();
    chk("cnt_b0", 32'(mem_rdata), 32'h64);
    mem_a = 32'h30005; step();
    chk("cnt_b1", 32'(mem_rdata), 32'h00);
    mem_a = 32'h30006; step();
    chk("cnt_b2", 32'(mem_rdata), 32'h00);
    mem_a = 32'h30007; step();
    chk("cnt_b3", 32'(mem_rdata), 32'h00);

    // RAM write then read-after-write.
    mem_wr = 1'b1; mem_a = 32'h10; mem_wdata = 8'hA5; step();
    mem_wr = 1'b0; step();
    chk("ram_10", 32'(mem_rdata), 32'hA5);
    mem_wr = 1'b1; mem_a = 32'h1FFFF; mem_wdata = 8'h3C; step();
    mem_wr = 1'b0; step();
    chk("ram_1ffff", 32'(mem_rdata), 32'h3C);

    // RX byte pop.
    rx_valid = 1'b1; rx_data = 8'h41; mem_a = 32'h30000; #1;
    chk("rx_ready_hi", 32'(rx_ready), 32'h1);
    step();
    chk("rx_data", 32'(mem_rdata), 32'h41);
    mem_a = 32'h10; #1;
    chk("rx_ready_once", 32'(rx_ready), 32'h0);
    rx_valid = 1'b0; mem_a = 32'h30000; #1;
    chk("rx_ready_novalid", 32'(rx_ready), 32'h0);
    step();
    chk("rx_empty_data", 32'(mem_rdata), 32'h00);
    mem_a = 32'h30002; step();
    chk("io_other_off", 32'(mem_rdata), 32'h00);

    // TX fill with a zero write in the middle, then overflow.
    tx_ready = 1'b0; mem_wr = 1'b1; mem_a = 32'h30000;
    for (int i = 1; i <= 16; i++) begin
      if (i == 14) begin
        mem_wdata = 8'h00; step();
        chk("zero_nopush", 32'(io_buffer_full), 32'h0);
      end
      mem_wdata = 8'(8'h60 + i); step();
      chk("full_level", 32'(io_buffer_full), 32'(i >= 14));
    end
    chk("ovf_before", 32'(tx_overflow), 32'h0);
    mem_wdata = 8'hEE; step();
    chk("ovf_after", 32'(tx_overflow), 32'h1);
    chk("tx_valid_full", 32'(tx_valid), 32'h1);

    // Drain in order.
    mem_wr = 1'b0; mem_a = 32'h10; tx_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("drain_data", 32'(tx_data), 32'(8'(8'h60 + i)));
      step();
    end
    chk("drain_empty", 32'(tx_valid), 32'h0);
    chk("drain_full", 32'(io_buffer_full), 32'h0);
    chk("ovf_sticky", 32'(tx_overflow), 32'h1);

    // Program stop, then a stalled bus while TX drains.
    tx_ready = 1'b0;
    mem_wr = 1'b1; mem_a = 32'h20; mem_wdata = 8'h11; step();
    mem_a = 32'h30004; mem_wdata = 8'h55; step();
    chk("stop_set", 32'(program_stop), 32'h1);
    chk("stop_tx_valid", 32'(tx_valid), 32'h1);
    chk("stop_tx_zero", 32'(tx_data), 32'h00);
    mem_wr = 1'b0; mem_a = 32'h30004; step();
    frozen = model_snap;
    chk("stop_cnt_b0", 32'(mem_rdata), 32'(frozen[7:0]));

    rdy_in = 1'b0; tx_ready = 1'b1;
    mem_wr = 1'b1; mem_a = 32'h20; mem_wdata = 8'hEE; step();
    chk("stall_tx_drain", 32'(tx_valid), 32'h0);
    chk("stall_rdata_hold", 32'(mem_rdata), 32'(frozen[7:0]));
    step(); step();
    mem_wr = 1'b0; mem_a = 32'h30000; rx_valid = 1'b1; rx_data = 8'h42; #1;
    chk("stall_rx_ready", 32'(rx_ready), 32'h0);
    step(); step();
    chk("stall_rdata_hold2", 32'(mem_rdata), 32'(frozen[7:0]));

    rdy_in = 1'b1; rx_valid = 1'b0;
    mem_a = 32'h30004; step();
    chk("frozen_b0", 32'(mem_rdata), 32'(frozen[7:0]));
    mem_a = 32'h30005; step();
    chk("frozen_b1", 32'(mem_rdata), 32'(frozen[15:8]));
    mem_a = 32'h30006; step();
    chk("frozen_b2", 32'(mem_rdata), 32'(frozen[23:16]));
    mem_a = 32'h30007; step();
    chk("frozen_b3", 32'(mem_rdata), 32'(frozen[31:24]));
    mem_a = 32'h20; step();
    chk("stall_no_write", 32'(mem_rdata), 32'h11);

    // Reset with bytes pending and flags set.
    tx_ready = 1'b0; mem_wr = 1'b1; mem_a = 32'h30000;
    for (int i = 1; i <= 5; i++) begin
      mem_wdata = 8'(8'h70 + i); step();
    end
    chk("pre_rst_tx", 32'(tx_valid), 32'h1);
    mem_wr = 1'b0; rst_in = 1'b1; step();
    rst_in = 1'b0;
    chk("rst2_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst2_stop", 32'(program_stop), 32'h0);
    chk("rst2_ovf", 32'(tx_overflow), 32'h0);
    chk("rst2_full", 32'(io_buffer_full), 32'h0);
    chk("rst2_rdata", 32'(mem_rdata), 32'h0);
    mem_a = 32'h30004; step();
    chk("rst2_cnt0", 32'(mem_rdata), 32'h00);
    step();
    chk("rst2_cnt1", 32'(mem_rdata), 32'h01);
    mem_a = 32'h10; step();
    chk("rst2_ram_10", 32'(mem_rdata), 32'hA5);
    mem_a = 32'h1FFFF; step();
    chk("rst2_ram_1ffff", 32'(mem_rdata), 32'h3C);
    mem_a = 32'h20; step();
    chk("rst2_ram_20", 32'(mem_rdata), 32'h11);

    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
